cfg_frame_loader: RTL and testbench

- Upstream feeder for the configuration consumers that use base_pkg::config_t.
- Accepts a 3-word configuration frame over a 32-bit valid/ready stream and assembles it into a config_t.
- Checks the frame (magic, max_width range) and returns a status response.
- Maintains the active configuration register, reset to the default config.

---
 rtl/cfg_frame_loader.sv | 158 +++++++++++++++
 tb/tb_cfg_frame_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cfg_frame_loader.sv
// Assembles a 3-word configuration frame into {version, features, max_width} and checks it.
// Returns a status response, applies good frames to active_cfg and counts bad ones.
module cfg_frame_loader #(
  parameter logic [15:0] MAGIC           = 16'hC0F6,
  parameter logic [31:0] MAX_WIDTH_LIMIT = 32'd1024,
  parameter int unsigned TIMEOUT_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [1:0]  resp_status,
  output logic [55:0] resp_cfg,
  output logic [55:0] active_cfg,
  output logic [7:0]  err_count
);

  // state | meaning
  // HDR   | waiting for header word (magic + version)
  // FEAT  | waiting for features word, timeout armed
  // WIDTH | waiting for max_width word, timeout armed
  // RESP  | response held until resp_ready
  typedef enum logic [1:0] {HDR, FEAT, WIDTH, RESP} state_t;

  localparam logic [1:0]  ST_SUCCESS  = 2'b00;
  localparam logic [1:0]  ST_FAILURE  = 2'b01;
  localparam logic [1:0]  ST_ERROR    = 2'b10;
  localparam logic [55:0] DEFAULT_CFG = {8'h01, 16'hFFFF, 32'd32};
  localparam logic [15:0] TO_LAST     = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  ver_q, ver_d;
  logic [15:0] feat_q, feat_d;
  logic [15:0] cnt_q, cnt_d;
  logic        in_ready_q, in_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [1:0]  resp_status_q, resp_status_d;
  logic [55:0] resp_cfg_q, resp_cfg_d;
  logic [55:0] active_q, active_d;
  logic [7:0]  err_q, err_d;

  logic        xfer;
  logic        raise;
  logic [1:0]  status_n;
  logic [55:0] cfg_n;
  logic        unused_hdr_bits;

  assign unused_hdr_bits = ^in_data[15:8];
  assign xfer = in_valid & in_ready_q;

  always_comb begin
    state_d       = state_q;
    ver_d         = ver_q;
    feat_d        = feat_q;
    cnt_d         = 16'd0;
    resp_valid_d  = resp_valid_q;
    resp_status_d = resp_status_q;
    resp_cfg_d    = resp_cfg_q;
    active_d      = active_q;
    err_d         = err_q;
    raise         = 1'b0;
    status_n      = ST_ERROR;
    cfg_n         = '0;

    case (state_q)
      HDR: begin
        if (xfer) begin
          if (in_data[31:16] == MAGIC) begin
            ver_d   = in_data[7:0];
            feat_d  = 16'd0;
            state_d = FEAT;
          end else begin
            raise = 1'b1;
            cfg_n = {in_data[7:0], 48'd0};
          end
        end
      end
      FEAT: begin
        if (xfer) begin
          feat_d  = in_data[15:0];
          state_d = WIDTH;
        end else if (cnt_q == TO_LAST) begin
          raise = 1'b1;
          cfg_n = {ver_q, 48'd0};
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WIDTH: begin
        if (xfer) begin
          raise    = 1'b1;
          cfg_n    = {ver_q, feat_q, in_data};
          status_n = (in_data != 32'd0 && in_data <= MAX_WIDTH_LIMIT) ? ST_SUCCESS : ST_FAILURE;
        end else if (cnt_q == TO_LAST) begin
          raise = 1'b1;
          cfg_n = {ver_q, feat_q, 32'd0};
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = HDR;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = HDR;
    endcase

    if (raise) begin
      state_d       = RESP;
      resp_valid_d  = 1'b1;
      resp_status_d = status_n;
      resp_cfg_d    = cfg_n;
      if (status_n == ST_SUCCESS) active_d = cfg_n;
      else if (err_q != 8'hFF)    err_d    = err_q + 8'd1;
    end

    in_ready_d = (state_d != RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= HDR;
      ver_q         <= 8'd0;
      feat_q        <= 16'd0;
      cnt_q         <= 16'd0;
      in_ready_q    <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_status_q <= 2'b00;
      resp_cfg_q    <= '0;
      active_q      <= DEFAULT_CFG;
      err_q         <= 8'd0;
    end else begin
      state_q       <= state_d;
      ver_q         <= ver_d;
      feat_q        <= feat_d;
      cnt_q         <= cnt_d;
      in_ready_q    <= in_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_status_q <= resp_status_d;
      resp_cfg_q    <= resp_cfg_d;
      active_q      <= active_d;
      err_q         <= err_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_status = resp_status_q;
  assign resp_cfg    = resp_cfg_q;
  assign active_cfg  = active_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Directed bench for cfg_frame_loader: good/bad frames, timeout boundary, response stall,
// error saturation and mid-frame reset, with hand-computed expectations.
module tb_cfg_frame_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_status;
  logic [55:0] resp_cfg;
  logic [55:0] active_cfg;
  logic [7:0]  err_count;

  int n_vec  = 0;
  int n_miss = 0;

  logic [55:0] exp_active;
  logic [7:0]  exp_err;

  localparam logic [55:0] DEF_CFG = {8'h01, 16'hFFFF, 32'h0000_0020};

  cfg_frame_loader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status),
    .resp_cfg(resp_cfg), .active_cfg(active_cfg), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; the word transfers on the next edge.
  task automatic xfer(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_resp(input string tag, input logic [1:0] st, input logic [55:0] cfg);
    if (st == 2'b00) exp_active = cfg;
    else if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    chk({tag, "_valid"},  64'(resp_valid),  64'd1);
    chk({tag, "_status"}, 64'(resp_status), 64'(st));
    chk({tag, "_cfg"},    64'(resp_cfg),    64'(cfg));
    chk({tag, "_active"}, 64'(active_cfg),  64'(exp_active));
    chk({tag, "_err"},    64'(err_count),   64'(exp_err));
    chk({tag, "_rdy_lo"}, 64'(in_ready),    64'd0);
  endtask

  // Assumes resp_ready = 1, so the handshake completes on the next edge.
  task automatic release_resp(input string tag);
    tick();
    chk({tag, "_drop"},   64'(resp_valid), 64'd0);
    chk({tag, "_rdy_hi"}, 64'(in_ready),   64'd1);
  endtask

  task automatic frame(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [1:0] st, input logic [55:0] cfg);
    xfer(w0);
    xfer(w1);
    chk({tag, "_pre"}, 64'(resp_valid), 64'd0);
    xfer(w2);
    expect_resp(tag, st, cfg);
    release_resp(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; resp_ready = 1'b1;
    exp_active = DEF_CFG;
    exp_err    = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",   64'(in_ready),    64'd1);
    chk("rst_resp_valid", 64'(resp_valid),  64'd0);
    chk("rst_status",     64'(resp_status), 64'd0);
    chk("rst_cfg",        64'(resp_cfg),    64'd0);
    chk("rst_err",        64'(err_count),   64'd0);
    chk("rst_active",     64'(active_cfg),  64'(DEF_CFG));
    rst_n = 1'b1;
    tick();

    frame("good1", 32'hC0F6_0002, 32'h0000_00A5, 32'h0000_0040, 2'b00,
          {8'h02, 16'h00A5, 32'h0000_0040});

    xfer(32'h1234_0002);
    expect_resp("badhdr", 2'b10, {8'h02, 16'h0000, 32'h0});
    release_resp("badhdr");

    frame("w_zero", 32'hC0F6_0005, 32'h0000_1111, 32'h0000_0000, 2'b01,
          {8'h05, 16'h1111, 32'h0});
    frame("w_401",  32'hC0F6_0006, 32'h0000_2222, 32'h0000_0401, 2'b01,
          {8'h06, 16'h2222, 32'h0000_0401});
    frame("w_400",  32'hC0F6_5507, 32'hFFFF_3333, 32'h0000_0400, 2'b00,
          {8'h07, 16'h3333, 32'h0000_0400});
    frame("w_max",  32'hC0F6_0008, 32'h0000_0001, 32'hFFFF_FFFF, 2'b01,
          {8'h08, 16'h0001, 32'hFFFF_FFFF});

    // Timeout in FEAT: 15 idle edges are tolerated, the 16th raises ERROR.
    xfer(32'hC0F6_0003);
    repeat (15) tick();
    chk("to_not_yet", 64'(resp_valid), 64'd0);
    tick();
    expect_resp("timeout", 2'b10, {8'h03, 16'h0000, 32'h0});
    release_resp("timeout");

    // Timeout in WIDTH keeps the latched features.
    xfer(32'hC0F6_0004);
    xfer(32'h0000_9999);
    repeat (15) tick();
    chk("to_w_not_yet", 64'(resp_valid), 64'd0);
    tick();
    expect_resp("timeout_w", 2'b10, {8'h04, 16'h9999, 32'h0});
    release_resp("timeout_w");

    // Word transferred in the final timeout cycle wins.
    xfer(32'hC0F6_0009);
    repeat (15) tick();
    xfer(32'h0000_4444);
    chk("to_edge_novalid", 64'(resp_valid), 64'd0);
    chk("to_edge_ready",   64'(in_ready),   64'd1);
    xfer(32'h0000_0010);
    expect_resp("to_edge", 2'b00, {8'h09, 16'h4444, 32'h0000_0010});
    release_resp("to_edge");

    // Response stalled 20 cycles with a header offered the whole time.
    resp_ready = 1'b0;
    xfer(32'hC0F6_000A);
    xfer(32'h0000_5555);
    xfer(32'h0000_0020);
    expect_resp("stall", 2'b00, {8'h0A, 16'h5555, 32'h0000_0020});
    in_valid = 1'b1;
    in_data  = 32'hC0F6_00EE;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stall_rdy",   64'(in_ready),   64'd0);
      chk("stall_valid", 64'(resp_valid), 64'd1);
    end
    chk("stall_status", 64'(resp_status), 64'd0);
    chk("stall_cfg",    64'(resp_cfg),    64'(56'h0A_5555_0000_0020));
    chk("stall_err",    64'(err_count),   64'(exp_err));
    in_valid = 1'b0;
    in_data  = 32'h0;
    resp_ready = 1'b1;
    release_resp("stall");
    frame("after_stall", 32'hC0F6_000B, 32'h0000_6666, 32'h0000_0001, 2'b00,
          {8'h0B, 16'h6666, 32'h0000_0001});

    // Saturation of err_count.
    for (int i = 0; i < 300; i++) begin
      xfer(32'hBEEF_00CC);
      if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
      chk("sat_err", 64'(err_count), 64'(exp_err));
      tick();
    end
    chk("sat_final", 64'(err_count), 64'hFF);
    chk("sat_active", 64'(active_cfg), 64'(exp_active));

    // Reset mid-frame.
    xfer(32'hC0F6_000D);
    xfer(32'h0000_1234);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_active = DEF_CFG;
    exp_err    = 8'd0;
    chk("mrst_valid",  64'(resp_valid), 64'd0);
    chk("mrst_ready",  64'(in_ready),   64'd1);
    chk("mrst_err",    64'(err_count),  64'd0);
    chk("mrst_active", 64'(active_cfg), 64'(DEF_CFG));
    frame("post_rst", 32'hC0F6_000C, 32'h0000_7777, 32'h0000_0080, 2'b00,
          {8'h0C, 16'h7777, 32'h0000_0080});

    // Reset while a response is pending.
    resp_ready = 1'b0;
    xfer(32'h5555_0001);
    expect_resp("pend", 2'b10, {8'h01, 16'h0, 32'h0});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    resp_ready = 1'b1;
    exp_active = DEF_CFG;
    exp_err    = 8'd0;
    chk("prst_valid",  64'(resp_valid), 64'd0);
    chk("prst_err",    64'(err_count),  64'd0);
    chk("prst_active", 64'(active_cfg), 64'(DEF_CFG));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
